// File: rtl/omi_mon_pkg.sv
// Shared error-bit map and channel state type for the OMI protocol monitor.
package omi_mon_pkg;

    localparam int unsigned ERR_W = 11;

    localparam int unsigned ERR_REQ_NOT_RDY     = 0;
    localparam int unsigned ERR_REQ_HELD        = 1;
    localparam int unsigned ERR_REQ_WHILE_BUSY  = 2;
    localparam int unsigned ERR_SIG_UNSTABLE    = 3;
    localparam int unsigned ERR_RDY_UNSTABLE    = 4;
    localparam int unsigned ERR_RDY_NOT_FALL    = 5;
    localparam int unsigned ERR_VALID_WHILE_RDY = 6;
    localparam int unsigned ERR_VALID_EARLY     = 7;
    localparam int unsigned ERR_BEAT_COUNT      = 8;
    localparam int unsigned ERR_TIMEOUT         = 9;
    localparam int unsigned ERR_MISALIGN        = 10;

    typedef enum logic [2:0] {
        StUnsync,
        StIdle,
        StAccept,
        StGap,
        StData
    } ch_state_e;

endpackage

// File: rtl/omi_mon_channel.sv
// One OMI channel checker: handshake FSM, request captures, beat count, watchdog and
// completed-transaction counter. new_err_o flags errors detected at the coming edge.
module omi_mon_channel
    import omi_mon_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned LEN_W       = 8,
    parameter int unsigned ALIGN_BYTES = 4,
    parameter int unsigned TIMEOUT     = 1024,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                req_i,
    input  logic                rdy_i,
    input  logic                valid_i,
    input  logic                wen_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W/8-1:0] ben_i,
    input  logic [LEN_W-1:0]    len_i,
    input  logic [DATA_W-1:0]   data_i,
    output logic [ERR_W-1:0]    new_err_o,
    output logic [CNT_W-1:0]    txn_cnt_o
);

    localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(ALIGN_BYTES - 1);

    ch_state_e           state_q;
    logic                req_q, rdy_q, wen_q, to_fired_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W/8-1:0] ben_q;
    logic [LEN_W-1:0]    len_q;
    logic [DATA_W-1:0]   data_q;
    logic [LEN_W:0]      beat_q;
    logic [WD_W-1:0]     wd_q;
    logic [CNT_W-1:0]    txn_cnt_q;

    logic req_rise, rdy_rise, accept, done, beat, wd_active, leave, wd_hit, sig_diff;

    always_comb begin
        req_rise  = req_i & ~req_q;
        rdy_rise  = rdy_i & ~rdy_q;
        accept    = (state_q == StIdle) & req_rise & rdy_i;
        done      = (state_q == StData) & rdy_rise;
        // A valid coinciding with the completing rdy edge is a protocol error, not a beat.
        beat      = (state_q == StData) & valid_i & ~rdy_rise;
        wd_active = state_q inside {StAccept, StGap, StData};
        leave     = ((state_q == StAccept) & ~rdy_i) | (state_q == StGap) | done;
        wd_hit    = (TIMEOUT != 0) && wd_active && !leave && !beat && !to_fired_q &&
                    (wd_q == WD_W'(TIMEOUT - 1));
        sig_diff  = (addr_i != addr_q) || (wen_i != wen_q) || (len_i != len_q) ||
                    (data_i != data_q) || (wen_q && (ben_i != ben_q));

        new_err_o = '0;
        case (state_q)
            StIdle: begin
                new_err_o[ERR_RDY_UNSTABLE] = ~req_i & rdy_q & ~rdy_i;
                new_err_o[ERR_REQ_NOT_RDY]  = req_rise & ~rdy_i;
                new_err_o[ERR_MISALIGN]     = accept && ((addr_i & ALIGN_MASK) != '0);
            end
            StAccept: begin
                new_err_o[ERR_RDY_NOT_FALL]    = rdy_i;
                new_err_o[ERR_VALID_WHILE_RDY] = rdy_i & valid_i;
                new_err_o[ERR_SIG_UNSTABLE]    = req_i & sig_diff;
            end
            StGap: begin
                new_err_o[ERR_REQ_HELD]    = req_i;
                new_err_o[ERR_VALID_EARLY] = valid_i;
            end
            StData: begin
                new_err_o[ERR_REQ_WHILE_BUSY]  = req_rise & ~rdy_i;
                new_err_o[ERR_BEAT_COUNT]      = done && (beat_q != {1'b0, len_q});
                new_err_o[ERR_VALID_WHILE_RDY] = done & valid_i;
            end
            default: ;
        endcase
        new_err_o[ERR_TIMEOUT] = wd_hit;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q    <= StUnsync;
            req_q      <= 1'b0;
            rdy_q      <= 1'b0;
            wen_q      <= 1'b0;
            addr_q     <= '0;
            ben_q      <= '0;
            len_q      <= '0;
            data_q     <= '0;
            beat_q     <= '0;
            wd_q       <= '0;
            to_fired_q <= 1'b0;
            txn_cnt_q  <= '0;
        end else begin
            req_q <= req_i;
            rdy_q <= rdy_i;
            case (state_q)
                StUnsync: if (rdy_i && !req_i) state_q <= StIdle;
                StIdle: begin
                    if (accept) begin
                        addr_q     <= addr_i;
                        wen_q      <= wen_i;
                        ben_q      <= ben_i;
                        len_q      <= len_i;
                        data_q     <= data_i;
                        beat_q     <= '0;
                        to_fired_q <= 1'b0;
                        state_q    <= StAccept;
                    end
                end
                StAccept: if (!rdy_i) state_q <= StGap;
                StGap:    state_q <= StData;
                StData: begin
                    if (done) begin
                        state_q <= StIdle;
                        if (txn_cnt_q != '1) txn_cnt_q <= txn_cnt_q + 1'b1;
                    end else if (beat && beat_q != '1) begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                default: state_q <= StUnsync;
            endcase
            // Restart on state entry and on every beat; saturate rather than wrap.
            if (wd_active && !leave && !beat) begin
                if (wd_q != '1) wd_q <= wd_q + 1'b1;
            end else begin
                wd_q <= '0;
            end
            if (wd_hit) to_fired_q <= 1'b1;
        end
    end

    assign txn_cnt_o = txn_cnt_q;

endmodule

// File: rtl/omi_protocol_monitor.sv
// Multi-channel OMI protocol monitor: per-channel checkers plus sticky error flags,
// a new-error pulse and first-error capture (lowest channel wins on a tie).
module omi_protocol_monitor
    import omi_mon_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned LEN_W       = 8,
    parameter int unsigned ALIGN_BYTES = 4,
    parameter int unsigned TIMEOUT     = 1024,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                         CLK,
    input  logic                         RESET_N,
    input  logic [NUM_CH-1:0]            req_i,
    input  logic [NUM_CH-1:0]            rdy_i,
    input  logic [NUM_CH-1:0]            valid_i,
    input  logic [NUM_CH-1:0]            wen_i,
    input  logic [NUM_CH*ADDR_W-1:0]     addr_i,
    input  logic [NUM_CH*DATA_W/8-1:0]   ben_i,
    input  logic [NUM_CH*LEN_W-1:0]      len_i,
    input  logic [NUM_CH*DATA_W-1:0]     data_i,
    input  logic                         clear_i,
    output logic [NUM_CH*ERR_W-1:0]      err_o,
    output logic                         err_pulse_o,
    output logic                         first_err_vld_o,
    output logic [$clog2(NUM_CH)-1:0]    first_err_ch_o,
    output logic [ERR_W-1:0]             first_err_code_o,
    output logic [NUM_CH*CNT_W-1:0]      txn_cnt_o
);

    localparam int unsigned CH_W = $clog2(NUM_CH);
    localparam int unsigned BW   = DATA_W / 8;

    logic [NUM_CH*ERR_W-1:0] new_err;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        omi_mon_channel #(
            .ADDR_W      (ADDR_W),
            .DATA_W      (DATA_W),
            .LEN_W       (LEN_W),
            .ALIGN_BYTES (ALIGN_BYTES),
            .TIMEOUT     (TIMEOUT),
            .CNT_W       (CNT_W)
        ) u_ch (
            .CLK       (CLK),
            .RESET_N   (RESET_N),
            .req_i     (req_i[g]),
            .rdy_i     (rdy_i[g]),
            .valid_i   (valid_i[g]),
            .wen_i     (wen_i[g]),
            .addr_i    (addr_i[g*ADDR_W +: ADDR_W]),
            .ben_i     (ben_i[g*BW +: BW]),
            .len_i     (len_i[g*LEN_W +: LEN_W]),
            .data_i    (data_i[g*DATA_W +: DATA_W]),
            .new_err_o (new_err[g*ERR_W +: ERR_W]),
            .txn_cnt_o (txn_cnt_o[g*CNT_W +: CNT_W])
        );
    end

    logic                    any_new;
    logic [CH_W-1:0]         sel_ch;
    logic [ERR_W-1:0]        sel_code;
    logic [NUM_CH*ERR_W-1:0] err_q;
    logic                    pulse_q, fe_vld_q;
    logic [CH_W-1:0]         fe_ch_q;
    logic [ERR_W-1:0]        fe_code_q;

    // Scan high to low so the lowest erroring channel ends up selected.
    always_comb begin
        any_new  = 1'b0;
        sel_ch   = '0;
        sel_code = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (|new_err[i*ERR_W +: ERR_W]) begin
                any_new  = 1'b1;
                sel_ch   = CH_W'(i);
                sel_code = new_err[i*ERR_W +: ERR_W];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            err_q     <= '0;
            pulse_q   <= 1'b0;
            fe_vld_q  <= 1'b0;
            fe_ch_q   <= '0;
            fe_code_q <= '0;
        end else begin
            err_q   <= (clear_i ? '0 : err_q) | new_err;
            pulse_q <= any_new;
            if (any_new && (!fe_vld_q || clear_i)) begin
                fe_vld_q  <= 1'b1;
                fe_ch_q   <= sel_ch;
                fe_code_q <= sel_code;
            end else if (clear_i) begin
                fe_vld_q  <= 1'b0;
                fe_ch_q   <= '0;
                fe_code_q <= '0;
            end
        end
    end

    assign err_o            = err_q;
    assign err_pulse_o      = pulse_q;
    assign first_err_vld_o  = fe_vld_q;
    assign first_err_ch_o   = fe_ch_q;
    assign first_err_code_o = fe_code_q;

endmodule

// File: tb/tb_omi_protocol_monitor.sv
// Bench for omi_protocol_monitor: tabled and random transactions judged by a
// transaction-level error model, plus directed watchdog, tie, clear and reset cases.
module tb_omi_protocol_monitor;

    localparam int NCH = 2, AW = 32, DW = 32, LW = 8, CW = 16, EW = 11;

    logic                 CLK = 1'b0;
    logic                 RESET_N;
    logic [NCH-1:0]       req, rdy, valid, wen;
    logic [NCH*AW-1:0]    addr;
    logic [NCH*DW/8-1:0]  ben;
    logic [NCH*LW-1:0]    len;
    logic [NCH*DW-1:0]    data;
    logic                 clear;
    logic [NCH*EW-1:0]    err_o;
    logic                 err_pulse_o, first_err_vld_o;
    logic [0:0]           first_err_ch_o;
    logic [EW-1:0]        first_err_code_o;
    logic [NCH*CW-1:0]    txn_cnt_o;

    int checks = 0, errors = 0, pulse_cnt = 0;
    int exp_txn [NCH];

    typedef struct {
        int ch, len, beats;
        bit wen, mis, sig, rdy_late, gapv, hold_gap, busy, endv;
        logic [10:0] exp_err, exp_first;
        int exp_pulses;
    } txn_t;

    txn_t tbl [9];

    omi_protocol_monitor #(
        .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW),
        .ALIGN_BYTES(4), .TIMEOUT(16), .CNT_W(CW)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .req_i(req), .rdy_i(rdy), .valid_i(valid),
        .wen_i(wen), .addr_i(addr), .ben_i(ben), .len_i(len), .data_i(data),
        .clear_i(clear), .err_o(err_o), .err_pulse_o(err_pulse_o),
        .first_err_vld_o(first_err_vld_o), .first_err_ch_o(first_err_ch_o),
        .first_err_code_o(first_err_code_o), .txn_cnt_o(txn_cnt_o)
    );

    always #5 CLK = ~CLK;
    always @(negedge CLK) if (err_pulse_o === 1'b1) pulse_cnt++;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic txn_t mk(int ch, int ln, int bt, bit w, bit mis, bit sig, bit rl,
                                bit gv, bit hg, bit bs, bit ev, logic [10:0] e,
                                logic [10:0] f, int p);
        txn_t t;
        t.ch = ch; t.len = ln; t.beats = bt; t.wen = w; t.mis = mis; t.sig = sig;
        t.rdy_late = rl; t.gapv = gv; t.hold_gap = hg; t.busy = bs; t.endv = ev;
        t.exp_err = e; t.exp_first = f; t.exp_pulses = p;
        return t;
    endfunction

    // Each protocol phase of a transaction is a separate cycle, so each phase with a
    // fault gives one pulse, and the earliest faulty phase is what first-error captures.
    function automatic txn_t predict(txn_t t);
        logic [10:0] st [5];
        st[0] = t.mis ? 11'h400 : 11'h000;
        st[1] = (t.rdy_late ? 11'h020 : 11'h000) | (t.sig ? 11'h008 : 11'h000);
        st[2] = (t.gapv ? 11'h080 : 11'h000) | (t.hold_gap ? 11'h002 : 11'h000);
        st[3] = t.busy ? 11'h004 : 11'h000;
        st[4] = (t.beats != t.len ? 11'h100 : 11'h000) | (t.endv ? 11'h040 : 11'h000);
        t.exp_err = '0; t.exp_first = '0; t.exp_pulses = 0;
        for (int s = 0; s < 5; s++) begin
            if (st[s] != 0) begin
                if (t.exp_first == 0) t.exp_first = st[s];
                t.exp_err |= st[s];
                t.exp_pulses++;
            end
        end
        return t;
    endfunction

    task automatic clear_errs();
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
        pulse_cnt = 0;
    endtask

    task automatic run_txn(txn_t t);
        int c = t.ch;
        logic [31:0] a;
        bit hold;
        a = $urandom() & 32'hFFFF_FFFC;
        if (t.mis) a[1:0] = 2'($urandom_range(1, 3));
        addr[c*AW +: AW]   = a;
        data[c*DW +: DW]   = $urandom();
        ben[c*4 +: 4]      = 4'($urandom());
        len[c*LW +: LW]    = 8'(t.len);
        wen[c]             = t.wen;
        req[c] = 1'b1;
        step();
        hold = t.sig || ($urandom_range(0, 1) == 1);
        rdy[c] = t.rdy_late;
        req[c] = hold;
        if (t.sig) addr[c*AW +: AW] = a ^ 32'h100;
        else if (hold && !t.wen) ben[c*4 +: 4] = ~ben[c*4 +: 4];
        step();
        if (t.rdy_late) begin
            rdy[c] = 1'b0;
            req[c] = 1'b0;
            step();
        end
        req[c] = t.hold_gap;
        valid[c] = t.gapv;
        step();
        req[c] = 1'b0;
        valid[c] = 1'b0;
        if (t.busy) begin
            step();
            req[c] = 1'b1;
            step();
            req[c] = 1'b0;
        end
        for (int b = 0; b < t.beats; b++) begin
            repeat ($urandom_range(0, 2)) step();
            valid[c] = 1'b1;
            step();
            valid[c] = 1'b0;
        end
        rdy[c] = 1'b1;
        valid[c] = t.endv;
        step();
        valid[c] = 1'b0;
        step();
        exp_txn[c]++;
    endtask

    task automatic check_txn(string tag, txn_t t);
        logic [21:0] e;
        e = 22'(t.exp_err) << (t.ch * EW);
        check({tag, "_err"}, 64'(err_o), 64'(e));
        check({tag, "_vld"}, 64'(first_err_vld_o), 64'(t.exp_err != 0));
        check({tag, "_ch"}, 64'(first_err_ch_o), (t.exp_err != 0) ? 64'(t.ch) : 64'd0);
        check({tag, "_code"}, 64'(first_err_code_o), 64'(t.exp_first));
        check({tag, "_pulses"}, 64'(pulse_cnt), 64'(t.exp_pulses));
        for (int c = 0; c < NCH; c++)
            check({tag, "_txn"}, 64'(txn_cnt_o[c*CW +: CW]), 64'(exp_txn[c]));
    endtask

    initial begin
        txn_t t;
        //           ch len bt w  mis sig rl gv hg bs ev  err     first   p
        tbl[0] = mk(0, 3, 3, 1, 0, 0, 0, 0, 0, 0, 0, 11'h000, 11'h000, 0);
        tbl[1] = mk(0, 3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 11'h100, 11'h100, 1);
        tbl[2] = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 11'h000, 11'h000, 0);
        tbl[3] = mk(1, 2, 2, 0, 0, 0, 0, 1, 0, 0, 0, 11'h080, 11'h080, 1);
        tbl[4] = mk(0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 11'h408, 11'h400, 2);
        tbl[5] = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 11'h040, 11'h040, 1);
        tbl[6] = mk(0, 2, 2, 1, 0, 0, 1, 0, 0, 0, 0, 11'h020, 11'h020, 1);
        tbl[7] = mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 11'h106, 11'h002, 3);
        tbl[8] = mk(0, 4, 5, 1, 0, 1, 0, 1, 0, 0, 1, 11'h1C8, 11'h008, 3);

        req = '0; rdy = '0; valid = '0; wen = '0; addr = '0; ben = '0; len = '0;
        data = '0; clear = 1'b0; RESET_N = 1'b0;
        for (int c = 0; c < NCH; c++) exp_txn[c] = 0;
        repeat (3) step();
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_pulse", 64'(err_pulse_o), 64'd0);
        check("rst_vld", 64'(first_err_vld_o), 64'd0);
        check("rst_code", 64'(first_err_code_o), 64'd0);
        check("rst_txn", 64'(txn_cnt_o), 64'd0);
        RESET_N = 1'b1;
        rdy = '1;
        step();
        step();

        for (int i = 0; i < 9; i++) begin
            clear_errs();
            run_txn(tbl[i]);
            check_txn($sformatf("tbl%0d", i), tbl[i]);
        end

        // Capture must stay on ch0 while a later ch1 error accumulates.
        clear_errs();
        run_txn(tbl[4]);
        run_txn(tbl[3]);
        check("hold_err", 64'(err_o), 64'((22'h080 << EW) | 22'h408));
        check("hold_ch", 64'(first_err_ch_o), 64'd0);
        check("hold_code", 64'(first_err_code_o), 64'h400);
        check("hold_pulses", 64'(pulse_cnt), 64'd3);

        // Same-cycle errors on both channels: ch0 wins the capture.
        clear_errs();
        rdy = '0;
        step();
        check("tie_err", 64'(err_o), 64'((22'h010 << EW) | 22'h010));
        check("tie_ch", 64'(first_err_ch_o), 64'd0);
        check("tie_code", 64'(first_err_code_o), 64'h010);
        rdy = '1;
        step();
        // A new error in the clear cycle survives and reloads the capture.
        rdy[1] = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_err", 64'(err_o), 64'(22'h010 << EW));
        check("clr_vld", 64'(first_err_vld_o), 64'd1);
        check("clr_ch", 64'(first_err_ch_o), 64'd1);
        check("clr_code", 64'(first_err_code_o), 64'h010);
        rdy[1] = 1'b1;
        step();

        // req rising while rdy is low in IDLE.
        rdy[0] = 1'b0;
        step();
        clear_errs();
        req[0] = 1'b1;
        step();
        check("rnr_err", 64'(err_o), 64'h001);
        req[0] = 1'b0;
        rdy[0] = 1'b1;
        step();

        // Watchdog: silent DATA phase fires once, then the transaction completes.
        clear_errs();
        addr[0 +: AW] = 32'h1000;
        len[0 +: LW] = 8'd1;
        wen[0] = 1'b0;
        req[0] = 1'b1;
        step();
        req[0] = 1'b0;
        rdy[0] = 1'b0;
        step();
        step();
        repeat (10) step();
        check("wd_early", 64'(err_o), 64'd0);
        repeat (10) step();
        check("wd_fire", 64'(err_o), 64'h200);
        check("wd_code", 64'(first_err_code_o), 64'h200);
        check("wd_pulses", 64'(pulse_cnt), 64'd1);
        valid[0] = 1'b1;
        step();
        valid[0] = 1'b0;
        rdy[0] = 1'b1;
        step();
        step();
        exp_txn[0]++;
        check("wd_after_err", 64'(err_o), 64'h200);
        check("wd_after_pulses", 64'(pulse_cnt), 64'd1);
        check("wd_txn", 64'(txn_cnt_o[0 +: CW]), 64'(exp_txn[0]));

        for (int i = 0; i < 40; i++) begin
            t.ch = $urandom_range(0, NCH - 1);
            t.len = $urandom_range(0, 6);
            t.beats = t.len;
            if ($urandom_range(0, 3) == 0)
                t.beats = (t.len == 0 || $urandom_range(0, 1) == 1) ? t.len + 1 : t.len - 1;
            t.wen      = 1'($urandom_range(0, 1));
            t.mis      = ($urandom_range(0, 9) < 2);
            t.sig      = ($urandom_range(0, 9) < 2);
            t.rdy_late = ($urandom_range(0, 9) < 1);
            t.gapv     = ($urandom_range(0, 9) < 2);
            t.hold_gap = ($urandom_range(0, 9) < 1);
            t.busy     = ($urandom_range(0, 9) < 1);
            t.endv     = ($urandom_range(0, 9) < 2);
            t = predict(t);
            clear_errs();
            run_txn(t);
            check_txn($sformatf("rnd%0d", i), t);
        end

        // Reset in the middle of DATA: nothing flagged, counters cleared, resync.
        clear_errs();
        len[0 +: LW] = 8'd3;
        req[0] = 1'b1;
        step();
        req[0] = 1'b0;
        rdy[0] = 1'b0;
        step();
        step();
        valid[0] = 1'b1;
        step();
        valid[0] = 1'b0;
        RESET_N = 1'b0;
        step();
        RESET_N = 1'b1;
        rdy = '1;
        pulse_cnt = 0;
        step();
        step();
        for (int c = 0; c < NCH; c++) exp_txn[c] = 0;
        check("rmid_err", 64'(err_o), 64'd0);
        check("rmid_vld", 64'(first_err_vld_o), 64'd0);
        check("rmid_txn", 64'(txn_cnt_o), 64'd0);
        check("rmid_pulses", 64'(pulse_cnt), 64'd0);
        run_txn(tbl[0]);
        check_txn("resync", tbl[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
